seg_ctrl: RTL and testbench

SEG_CTRL -- requirements
Module: seg_ctrl

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_dist.sv | 23 ++
 rtl/seg_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seg_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and defaults for the segmentation controller.
package seg_pkg;

    localparam int unsigned SEG_MAX_CLUSTERS = 16;

    typedef logic [23:0] pixel_t;
    typedef logic [17:0] dist_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPixRd,
        StPixWait,
        StCmp,
        StWr,
        StDone
    } state_t;

endpackage

// File: rtl/seg_dist.sv
// Combinational squared RGB distance between two 24-bit pixels.
module seg_dist
    import seg_pkg::*;
(
    input  pixel_t a_i,
    input  pixel_t b_i,
    output dist_t  dist_o
);

    function automatic logic [15:0] sq_diff(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] d;
        d = (x > y) ? (x - y) : (y - x);
        return 16'(d) * 16'(d);
    endfunction

    // Worst case 3*255^2 = 195075 fits in 18 bits.
    always_comb begin
        dist_o = 18'(sq_diff(a_i[23:16], b_i[23:16]))
               + 18'(sq_diff(a_i[15:8],  b_i[15:8]))
               + 18'(sq_diff(a_i[7:0],   b_i[7:0]));
    end

endmodule

// File: rtl/seg_ctrl.sv
// Nearest-cluster image segmentation controller.
// SEG_CTRL_LABEL_EN: write the winning cluster index instead of its center colour.
module seg_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned MAX_CLUSTERS = SEG_MAX_CLUSTERS,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       num_pixels,
    input  logic [4:0]        num_clusters,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              img_ena,
    output logic [ADDR_W-1:0] img_addra,
    input  logic [23:0]       img_douta,
    output logic              img_enb,
    output logic [ADDR_W-1:0] img_addrb,
    input  logic [23:0]       img_doutb,
    output logic              ip_enc,
    output logic              ip_wec,
    output logic [ADDR_W-1:0] ip_addrc,
    output logic [23:0]       ip_doutc
);

    localparam int unsigned IdxW = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;

    state_t          state_q, state_d;
    logic [31:0]     n_q, n_d, p_q, p_d;
    logic [4:0]      k_q, k_d, cnt_q, cnt_d;
    logic            err_q, err_d;
    pixel_t          pix_q, pix_d;
    dist_t           best_q, best_d;
    logic [IdxW-1:0] best_idx_q, best_idx_d;
    pixel_t          ctr_q [MAX_CLUSTERS];
    logic            ctr_we;
    logic [IdxW-1:0] ctr_widx;
    pixel_t          cmp_ctr;
    dist_t           cand;
    logic            k_bad;

    assign k_bad   = (num_clusters == 5'd0) || (32'(num_clusters) > MAX_CLUSTERS);
    assign cmp_ctr = ctr_q[IdxW'(cnt_q)];

    seg_dist u_dist (
        .a_i   (pix_q),
        .b_i   (cmp_ctr),
        .dist_o(cand)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        p_d        = p_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pix_d      = pix_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        ctr_we     = 1'b0;
        ctr_widx   = IdxW'(cnt_q - 5'd1);
        busy       = (state_q != StIdle);
        done       = 1'b0;
        err        = 1'b0;
        img_ena    = 1'b0;
        img_addra  = '0;
        img_enb    = 1'b0;
        img_addrb  = '0;
        ip_enc     = 1'b0;
        ip_wec     = 1'b0;
        ip_addrc   = '0;
        ip_doutc   = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d   = num_pixels;
                    k_d   = num_clusters;
                    p_d   = '0;
                    cnt_d = '0;
                    err_d = k_bad;
                    if (k_bad || (num_pixels == 32'd0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                // Address cnt issued while data for cnt-1 returns; one trailing drain cycle.
                if (cnt_q != k_q) begin
                    img_enb   = 1'b1;
                    img_addrb = ADDR_W'(cnt_q);
                end
                ctr_we = (cnt_q != 5'd0);
                if (cnt_q == k_q) begin
                    cnt_d   = '0;
                    state_d = StPixRd;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StPixRd: begin
                img_ena   = 1'b1;
                img_addra = ADDR_W'(p_q);
                state_d   = StPixWait;
            end
            StPixWait: begin
                pix_d   = img_douta;
                cnt_d   = '0;
                state_d = StCmp;
            end
            StCmp: begin
                // Strict compare keeps the lowest index on ties.
                if ((cnt_q == 5'd0) || (cand < best_q)) begin
                    best_d     = cand;
                    best_idx_d = IdxW'(cnt_q);
                end
                if (cnt_q == k_q - 5'd1) begin
                    state_d = StWr;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StWr: begin
                ip_enc   = 1'b1;
                ip_wec   = 1'b1;
                ip_addrc = ADDR_W'(p_q);
`ifdef SEG_CTRL_LABEL_EN
                ip_doutc = pixel_t'(best_idx_q);
`else
                ip_doutc = ctr_q[best_idx_q];
`endif
                p_d     = p_q + 32'd1;
                state_d = (p_q + 32'd1 == n_q) ? StDone : StPixRd;
            end
            StDone: begin
                done    = 1'b1;
                err     = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            p_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pix_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            p_q        <= p_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pix_q      <= pix_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_CLUSTERS); i++) begin
                ctr_q[i] <= '0;
            end
        end else if (ctr_we) begin
            ctr_q[ctr_widx] <= img_doutb;
        end
    end

endmodule

// File: tb/tb_seg_ctrl.sv
// Directed, table-driven bench for seg_ctrl with simple 1-cycle-latency memory models.
module tb_seg_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_pixels;
    logic [4:0]  num_clusters;
    logic        busy, done, err;
    logic        img_ena, img_enb, ip_enc, ip_wec;
    logic [31:0] img_addra, img_addrb, ip_addrc;
    logic [23:0] img_douta, img_doutb, ip_doutc;

    always #5 clk = ~clk;

    seg_ctrl #(
        .MAX_CLUSTERS(16),
        .ADDR_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_pixels  (num_pixels),
        .num_clusters(num_clusters),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .img_ena     (img_ena),
        .img_addra   (img_addra),
        .img_douta   (img_douta),
        .img_enb     (img_enb),
        .img_addrb   (img_addrb),
        .img_doutb   (img_doutb),
        .ip_enc      (ip_enc),
        .ip_wec      (ip_wec),
        .ip_addrc    (ip_addrc),
        .ip_doutc    (ip_doutc)
    );

    logic [23:0] cmem [32];
    logic [23:0] imem [16];

    always @(posedge clk) begin
        if (img_enb) img_doutb <= cmem[img_addrb[4:0]];
        if (img_ena) img_douta <= imem[img_addra[3:0]];
    end

    int          n_ena, n_enb, n_acc, n_viol, wr_n;
    logic [31:0] wr_addr [32];
    logic [23:0] wr_data [32];

    always @(negedge clk) begin
        if (img_ena) n_ena++;
        if (img_enb) n_enb++;
        if (img_ena || img_enb || ip_enc || ip_wec) n_acc++;
        if ((!img_ena && img_addra != 0) || (!img_enb && img_addrb != 0) ||
            (!ip_enc && ip_addrc != 0)) n_viol++;
        if (ip_enc && ip_wec) begin
            if (wr_n < 32) begin
                wr_addr[wr_n] = ip_addrc;
                wr_data[wr_n] = ip_doutc;
            end
            wr_n++;
        end
    end

    typedef struct {
        logic [4:0]        k;
        logic [31:0]       n;
        logic [15:0][23:0] ctr;
        logic [7:0][23:0]  pix;
        logic [7:0][23:0]  col;
        logic [7:0][4:0]   lab;
        logic              err;
        int                done_at;
        logic              restart;
    } vec_t;

    vec_t v [9];
    vec_t vr;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input vec_t x, input int i);
`ifdef SEG_CTRL_LABEL_EN
        return {19'b0, x.lab[i]};
`else
        return x.col[i];
`endif
    endfunction

    function automatic vec_t mk(input logic [4:0] k, input logic [31:0] n, input int d);
        vec_t x;
        x         = '{default: '0};
        x.k       = k;
        x.n       = n;
        x.done_at = d;
        return x;
    endfunction

    task automatic clear_counts();
        n_ena  = 0;
        n_enb  = 0;
        n_acc  = 0;
        n_viol = 0;
        wr_n   = 0;
    endtask

    task automatic load_mems(input vec_t x);
        for (int j = 0; j < 16; j++) cmem[j] = x.ctr[j];
        for (int j = 0; j < 8; j++) imem[j] = x.pix[j];
    endtask

    task automatic run_job(input vec_t x, input string tag);
        int n, nw, nk, extra;
        load_mems(x);
        nw = x.err ? 0 : int'(x.n);
        nk = (nw == 0) ? 0 : int'(x.k);
        @(negedge clk); #1;
        clear_counts();
        num_pixels   = x.n;
        num_clusters = x.k;
        start        = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n     = 1;
        while (!done && n < 200) begin
            @(negedge clk); #1;
            n++;
            start = (x.restart && n == 5);
        end
        start = 1'b0;
        check({tag, " done_cycle"}, n, x.done_at);
        check({tag, " err"}, {31'b0, err}, {31'b0, x.err});
        check({tag, " busy_in_done"}, {31'b0, busy}, 32'd1);
        @(negedge clk); #1;
        check({tag, " idle_after"}, {30'b0, done, busy}, 32'd0);
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (done || busy) extra++;
        end
        check({tag, " no_rerun"}, extra, 0);
        check({tag, " writes"}, wr_n, nw);
        for (int i = 0; i < nw; i++) begin
            check($sformatf("%s addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s data%0d", tag, i), {8'b0, wr_data[i]}, {8'b0, exp_word(x, i)});
        end
        check({tag, " ena_cycles"}, n_ena, nw);
        check({tag, " enb_cycles"}, n_enb, nk);
        check({tag, " acc_cycles"}, n_acc, nk + 2 * nw);
        check({tag, " idle_addr_zero"}, n_viol, 0);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        num_pixels   = '0;
        num_clusters = '0;
        clear_counts();

        v[0] = mk(5'd2, 32'd2, 14);
        v[0].ctr[0] = 24'h000000; v[0].ctr[1] = 24'hFFFFFF;
        v[0].pix[0] = 24'h101010; v[0].pix[1] = 24'hF0F0F0;
        v[0].col[0] = 24'h000000; v[0].col[1] = 24'hFFFFFF;
        v[0].lab[0] = 5'd0;       v[0].lab[1] = 5'd1;

        v[1] = mk(5'd2, 32'd1, 9);
        v[1].ctr[0] = 24'h100000; v[1].ctr[1] = 24'h300000;
        v[1].pix[0] = 24'h200000; v[1].col[0] = 24'h100000; v[1].lab[0] = 5'd0;

        v[2] = mk(5'd0, 32'd3, 1);  v[2].err = 1'b1;
        v[3] = mk(5'd17, 32'd1, 1); v[3].err = 1'b1;
        v[4] = mk(5'd4, 32'd0, 1);

        v[5] = mk(5'd3, 32'd3, 23);
        v[5].restart = 1'b1;
        v[5].ctr[0] = 24'hFF0000; v[5].ctr[1] = 24'h00FF00; v[5].ctr[2] = 24'h0000FF;
        v[5].pix[0] = 24'hE01010; v[5].pix[1] = 24'h10F020; v[5].pix[2] = 24'h2020C0;
        v[5].col[0] = 24'hFF0000; v[5].col[1] = 24'h00FF00; v[5].col[2] = 24'h0000FF;
        v[5].lab[0] = 5'd0;       v[5].lab[1] = 5'd1;       v[5].lab[2] = 5'd2;

        v[6] = mk(5'd1, 32'd2, 11);
        v[6].ctr[0] = 24'h123456;
        v[6].pix[0] = 24'h000000; v[6].pix[1] = 24'hFFFFFF;
        v[6].col[0] = 24'h123456; v[6].col[1] = 24'h123456;

        v[7] = mk(5'd4, 32'd2, 20);
        v[7].ctr[0] = 24'h000000; v[7].ctr[1] = 24'h808080;
        v[7].ctr[2] = 24'h404040; v[7].ctr[3] = 24'hC0C0C0;
        v[7].pix[0] = 24'h7F7F7F; v[7].pix[1] = 24'h606060;
        v[7].col[0] = 24'h808080; v[7].col[1] = 24'h808080;
        v[7].lab[0] = 5'd1;       v[7].lab[1] = 5'd1;

        v[8] = mk(5'd16, 32'd2, 56);
        for (int j = 0; j < 16; j++) v[8].ctr[j] = 24'(j * 32'h101010);
        v[8].pix[0] = 24'hF8F8F8; v[8].pix[1] = 24'h050505;
        v[8].col[0] = 24'hF0F0F0; v[8].col[1] = 24'h000000;
        v[8].lab[0] = 5'd15;      v[8].lab[1] = 5'd0;

        vr = mk(5'd2, 32'd8, 44);
        vr.ctr[0] = 24'h000000; vr.ctr[1] = 24'hFFFFFF;
        for (int j = 0; j < 8; j++) begin
            vr.pix[j] = (j % 2 == 0) ? 24'h101010 : 24'hF0F0F0;
            vr.col[j] = (j % 2 == 0) ? 24'h000000 : 24'hFFFFFF;
            vr.lab[j] = (j % 2 == 0) ? 5'd0 : 5'd1;
        end

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {25'b0, busy, done, err, img_ena, img_enb, ip_enc, ip_wec}, 32'd0);
        check("reset_doutc", {8'b0, ip_doutc}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("post_reset_quiet", n_acc + wr_n, 0);

        for (int i = 0; i < 9; i++) begin
            run_job(v[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while comparing pixel 3 of an 8-pixel job.
        load_mems(vr);
        @(negedge clk); #1;
        clear_counts();
        num_pixels   = vr.n;
        num_clusters = vr.k;
        start        = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n     = 1;
        while (n < 21) begin
            @(negedge clk); #1;
            n++;
        end
        check("midjob_writes_before_rst", wr_n, 3);
        check("midjob_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_ctrl", {25'b0, busy, done, err, img_ena, img_enb, ip_enc, ip_wec}, 32'd0);
        check("rst_addr", img_addra | img_addrb | ip_addrc, 32'd0);
        check("rst_doutc", {8'b0, ip_doutc}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        clear_counts();
        repeat (5) @(negedge clk);
        #1;
        check("rst_release_quiet", n_acc + wr_n, 0);
        check("rst_release_idle", {31'b0, busy}, 32'd0);
        run_job(vr, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
